// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants for the write-back stage and register file.
// The fixed zero register index lives here so every consumer agrees on it.
package wb_regfile_pkg;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 5;
    localparam int          NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 0;

    // A register write only takes effect when enabled and not aimed at R0.
    function automatic logic is_commit(input logic reg_w, input logic addr_is_zero);
        return reg_w && !addr_is_zero;
    endfunction

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Two-read / one-write architectural register storage with async reset.
// R0 always reads as zero and is never written.
module wb_regfile_regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
    parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage update: cleared on reset, single write port otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != ADDR_W'(ZERO_REG))) begin
            regs[waddr] <= wdata;
        end else begin
            regs <= regs;
        end
    end

    // Read ports with R0 masked to zero regardless of storage contents.
    always_comb begin
        rdata_a = {DATA_W{1'b0}};
        rdata_b = {DATA_W{1'b0}};
        if (raddr_a != ADDR_W'(ZERO_REG)) begin
            rdata_a = regs[raddr_a];
        end else begin
            rdata_a = {DATA_W{1'b0}};
        end
        if (raddr_b != ADDR_W'(ZERO_REG)) begin
            rdata_b = regs[raddr_b];
        end else begin
            rdata_b = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects load vs ALU data, commits it to the register file,
// bypasses same-cycle writes to the ID read ports and keeps a debug write trace.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
    parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Mem_r_data_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [ADDR_W-1:0] Rd_addr_in,
    input  logic              Reg_w_in,
    input  logic              Mem_to_reg_in,
    input  logic [ADDR_W-1:0] Rs_addr,
    input  logic [ADDR_W-1:0] Rt_addr,
    output logic [DATA_W-1:0] Rs_data,
    output logic [DATA_W-1:0] Rt_data,
    output logic [DATA_W-1:0] Wb_data_out,
    output logic [31:0]       Wb_count,
    output logic [ADDR_W-1:0] Last_w_addr,
    output logic [DATA_W-1:0] Last_w_data
);

    logic              commit;
    logic [DATA_W-1:0] store_rs;
    logic [DATA_W-1:0] store_rt;
    logic [31:0]       count_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [DATA_W-1:0] last_data_r;

    assign Wb_data_out = Mem_to_reg_in ? Mem_r_data_in : ALU_result_in;
    assign commit      = is_commit(Reg_w_in, Rd_addr_in == ADDR_W'(ZERO_REG));

    wb_regfile_regfile_2r1w #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .waddr   (Rd_addr_in),
        .wdata   (Wb_data_out),
        .raddr_a (Rs_addr),
        .raddr_b (Rt_addr),
        .rdata_a (store_rs),
        .rdata_b (store_rt)
    );

    // Same-cycle bypass so ID sees a value being written back this cycle.
    always_comb begin
        Rs_data = store_rs;
        Rt_data = store_rt;
        if (commit && (Rs_addr == Rd_addr_in)) begin
            Rs_data = Wb_data_out;
        end else begin
            Rs_data = store_rs;
        end
        if (commit && (Rt_addr == Rd_addr_in)) begin
            Rt_data = Wb_data_out;
        end else begin
            Rt_data = store_rt;
        end
    end

    // Commit counter and last-write record for trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 32'd0;
            last_addr_r <= {ADDR_W{1'b0}};
            last_data_r <= {DATA_W{1'b0}};
        end else if (commit) begin
            count_r     <= count_r + 32'd1;
            last_addr_r <= Rd_addr_in;
            last_data_r <= Wb_data_out;
        end else begin
            count_r     <= count_r;
            last_addr_r <= last_addr_r;
            last_data_r <= last_data_r;
        end
    end

    assign Wb_count    = count_r;
    assign Last_w_addr = last_addr_r;
    assign Last_w_data = last_data_r;

endmodule
